elastic_pipe: RTL and testbench

Parametrised elastic pipeline for the datapath test harness: STAGES register stages, each applying a fixed per-stage bit-set transform to a WIDTH-bit word. Every stage carries a one-entry skid buffer, so valid/ready backpressure never drops or duplicates a word and throughput stays at one word per cycle. It succeeds the fixed five-stage, stall-driven pipeline unit. It adds:
- configurable width and depth;
- a full upstream handshake;
- a flush that empties the pipe;
- an occupancy output.

---
 rtl/elastic_pipe.sv | 136 +++++++++++++
 tb/tb_elastic_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe.sv
// elastic_pipe: STAGES-deep valid/ready pipeline; each stage ORs in one bit and owns a
// one-entry skid buffer. Defining ELASTIC_PIPE_PERF_EN adds accepted/stall counters.
module elastic_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5,
    parameter int OCC_W  = $clog2(2*STAGES+1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
`ifdef ELASTIC_PIPE_PERF_EN
    output logic [OCC_W-1:0] occupancy,
    output logic [31:0]      accepted_cnt,
    output logic [31:0]      stall_cnt
`else
    output logic [OCC_W-1:0] occupancy
`endif
);
    // Index gi carries the word offered to stage gi; index STAGES is the pipe output.
    logic [STAGES:0]  fwd_valid;
    logic [WIDTH-1:0] fwd_data [STAGES+1];
    logic [STAGES:0]  rdy;

    assign fwd_valid[0] = in_valid;
    assign fwd_data[0]  = in_data;
    assign rdy[STAGES]  = out_ready;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam logic [WIDTH-1:0] STAGE_MASK = WIDTH'(1) << (gi % WIDTH);

            logic [WIDTH-1:0] main_data_reg;
            logic [WIDTH-1:0] skid_data_reg;
            logic             main_valid_reg;
            logic             skid_full_reg;
            logic [WIDTH-1:0] word;
            logic             arrive;
            logic             take;

            assign word   = fwd_data[gi] | STAGE_MASK;
            assign arrive = fwd_valid[gi] && !skid_full_reg;
            assign take   = main_valid_reg && rdy[gi+1];

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    main_data_reg  <= '0;
                    skid_data_reg  <= '0;
                    main_valid_reg <= 1'b0;
                    skid_full_reg  <= 1'b0;
                end else if (flush) begin
                    main_valid_reg <= 1'b0;
                    skid_full_reg  <= 1'b0;
                end else if (take) begin
                    if (skid_full_reg) begin
                        // ready was low this cycle, so nothing can arrive alongside
                        main_data_reg <= skid_data_reg;
                        skid_full_reg <= 1'b0;
                    end else begin
                        main_valid_reg <= arrive;
                        if (arrive) begin
                            main_data_reg <= word;
                        end
                    end
                end else if (!main_valid_reg) begin
                    main_valid_reg <= arrive;
                    if (arrive) begin
                        main_data_reg <= word;
                    end
                end else if (arrive) begin
                    skid_data_reg <= word;
                    skid_full_reg <= 1'b1;
                end
            end

            assign fwd_valid[gi+1] = main_valid_reg;
            assign fwd_data[gi+1]  = main_data_reg;
            assign rdy[gi]         = !skid_full_reg;
        end
    endgenerate

    assign in_ready  = rdy[0];
    assign out_valid = fwd_valid[STAGES];
    assign out_data  = fwd_data[STAGES];

    logic             up_xfer;
    logic             down_xfer;
    logic [OCC_W-1:0] occ_reg;

    assign up_xfer   = in_valid && in_ready;
    assign down_xfer = out_valid && out_ready;

    // Tracks the popcount of all valid/full bits incrementally from the two handshakes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ_reg <= '0;
        end else if (flush) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_reg + OCC_W'(up_xfer) - OCC_W'(down_xfer);
        end
    end

    assign occupancy = occ_reg;

`ifdef ELASTIC_PIPE_PERF_EN
    logic [31:0] accepted_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            accepted_cnt_reg <= '0;
            stall_cnt_reg    <= '0;
        end else if (flush) begin
            accepted_cnt_reg <= '0;
            stall_cnt_reg    <= '0;
        end else begin
            if (up_xfer) begin
                accepted_cnt_reg <= accepted_cnt_reg + 32'd1;
            end
            if (out_valid && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign accepted_cnt = accepted_cnt_reg;
    assign stall_cnt    = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard bench for elastic_pipe: three instances (5, 1 and 16 stages) share stimulus;
// a negedge monitor checks output order/values and occupancy against per-instance FIFOs.
module tb_elastic_pipe;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic in_valid;
    logic out_ready;
    logic flush;
    logic [31:0] in_data;

    logic [NDUT-1:0]       in_ready_v;
    logic [NDUT-1:0]       out_valid_v;
    logic [NDUT-1:0][31:0] out_data_v;
    logic [NDUT-1:0][7:0]  occ_v;
`ifdef ELASTIC_PIPE_PERF_EN
    logic [NDUT-1:0][31:0] acc_v;
    logic [NDUT-1:0][31:0] stall_v;
`endif

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int S  = (gi == 0) ? 5 : ((gi == 1) ? 1 : 16);
        localparam int OW = $clog2(2 * S + 1);
        logic [OW-1:0] occ_w;

        elastic_pipe #(.WIDTH(32), .STAGES(S)) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .in_data      (in_data),
            .in_valid     (in_valid),
            .in_ready     (in_ready_v[gi]),
            .out_data     (out_data_v[gi]),
            .out_valid    (out_valid_v[gi]),
            .out_ready    (out_ready),
            .flush        (flush),
`ifdef ELASTIC_PIPE_PERF_EN
            .accepted_cnt (acc_v[gi]),
            .stall_cnt    (stall_v[gi]),
`endif
            .occupancy    (occ_w)
        );
        assign occ_v[gi] = 8'(occ_w);
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q [NDUT][$];

    // Reference transform: the stage masks together set the low S bits.
    function automatic logic [31:0] expect_word(int d, logic [31:0] w);
        int s;
        s = (d == 0) ? 5 : ((d == 1) ? 1 : 16);
        return w | ((s >= 32) ? 32'hFFFF_FFFF : ((32'd1 << s) - 32'd1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    // At each negedge the inputs describe the coming edge, so the queues are updated
    // to the state that edge will produce; occupancy reflects the previous edge.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (!reset_n) begin
                    exp_q[d].delete();
                end else begin
                    check($sformatf("occ_dut%0d", d), 32'(occ_v[d]), 32'(exp_q[d].size()));
                    if (out_valid_v[d] && out_ready) begin
                        if (exp_q[d].size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_out_dut%0d: got 0x%08h required no word", d, out_data_v[d]);
                        end else begin
                            check($sformatf("out_dut%0d", d), out_data_v[d], exp_q[d].pop_front());
                        end
                    end
                    if (flush) exp_q[d].delete();
                    else if (in_valid && in_ready_v[d]) exp_q[d].push_back(expect_word(d, in_data));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int idx;
    int seen;
    bit acc;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        out_ready = 1'b1;
        flush     = 1'b0;
        fork
            monitor();
        join_none

        // Reset held three cycles with in_valid high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
            check("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
            check("rst_occ", 32'(occ_v[0]), 32'd0);
            check("rst_out_data", out_data_v[0], 32'd0);
        end
        reset_n = 1'b1;
        tick();
        check("first_accept_occ", 32'(occ_v[0]), 32'd1);
        in_valid = 1'b0;
        repeat (20) tick();

        // Streaming latency and back-to-back output
        in_valid = 1'b1; in_data = 32'h100; tick();
        check("lat_e0", 32'(out_valid_v[0]), 32'd0);
        in_data = 32'h200; tick();
        check("lat_e1", 32'(out_valid_v[0]), 32'd0);
        in_data = 32'h300; tick();
        in_valid = 1'b0;
        check("lat_e2", 32'(out_valid_v[0]), 32'd0);
        tick();
        check("lat_e3", 32'(out_valid_v[0]), 32'd0);
        tick();
        check("stream0_valid", 32'(out_valid_v[0]), 32'd1);
        check("stream0_data", out_data_v[0], 32'h11F);
        tick();
        check("stream1_data", out_data_v[0], 32'h21F);
        tick();
        check("stream2_data", out_data_v[0], 32'h31F);
        tick();
        check("stream_end", 32'(out_valid_v[0]), 32'd0);
        repeat (20) tick();

        // Backpressure: fill the pipe, then release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            in_data = 32'(idx);
            acc = in_ready_v[0];
            tick();
            if (acc) idx++;
        end
        check("bp_in_ready", 32'(in_ready_v[0]), 32'd0);
        check("bp_occ", 32'(occ_v[0]), 32'd10);
        check("bp_accepted", 32'(idx), 32'd10);
        out_ready = 1'b1;
        for (int c = 0; c < 60 && idx < 16; c++) begin
            in_data = 32'(idx);
            acc = in_ready_v[0];
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_in", 32'(idx), 32'd16);
        repeat (40) tick();

        // Flush at occupancy 7 together with an upstream word 0xAA
        out_ready = 1'b0;
        for (int c = 0; c < 40 && occ_v[0] != 8'd7; c++) begin
            in_valid = (occ_v[0] < 8'd7);
            in_data  = 32'h40 + 32'(c);
            tick();
        end
        in_valid = 1'b0;
        check("flush_pre_occ", 32'(occ_v[0]), 32'd7);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hAA;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_occ", 32'(occ_v[0]), 32'd0);
        check("flush_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("flush_in_ready", 32'(in_ready_v[0]), 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid_v[0]) seen++;
        end
        check("flush_no_stale", 32'(seen), 32'd0);

        // Random handshakes with rare flushes
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 499) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (40) tick();
        for (int d = 0; d < NDUT; d++) check($sformatf("drain_dut%0d", d), 32'(exp_q[d].size()), 32'd0);

        // Reset in the middle of traffic
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
        repeat (6) tick();
        reset_n = 1'b0; tick();
        reset_n = 1'b1; in_valid = 1'b0;
        check("midrst_occ", 32'(occ_v[0]), 32'd0);
        check("midrst_out_valid", 32'(out_valid_v[0]), 32'd0);
        out_ready = 1'b1;
        repeat (20) tick();

`ifdef ELASTIC_PIPE_PERF_EN
        flush = 1'b1; tick(); flush = 1'b0;
        check("perf_acc_clr", acc_v[0], 32'd0);
        check("perf_stall_clr", stall_v[0], 32'd0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !out_valid_v[0]; c++) tick();
        check("perf_out_valid", 32'(out_valid_v[0]), 32'd1);
        check("perf_stall0", stall_v[0], 32'd0);
        repeat (8) tick();
        check("perf_stall8", stall_v[0], 32'd8);
        check("perf_acc1", acc_v[0], 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("perf_acc_flush", acc_v[0], 32'd0);
        check("perf_stall_flush", stall_v[0], 32'd0);
        out_ready = 1'b1;
        repeat (5) tick();
`endif

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
